// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter feeding the integer register file write port.
// Two source queues (ALU, load/store) of DEPTH entries each, round-robin grant,
// registered write strobe/address/data, and a pending-register mask.
// Optional same-cycle read bypass is built when WB_BYPASS_EN is defined.
module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic        flush,
    output logic        w_enable,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    output logic [31:0] pending
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd1_data,
    output logic [31:0] fwd2_data
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Index 0 is the ALU queue, index 1 the load/store queue.
    logic [1:0]  w_valid;
    logic [1:0]  w_ready;
    logic [1:0]  w_push;
    logic [1:0]  w_pop;
    logic [1:0]  w_nonempty;
    logic [4:0]  w_in_rd     [2];
    logic [31:0] w_in_data   [2];
    logic [4:0]  w_head_rd   [2];
    logic [31:0] w_head_data [2];
    logic [31:0] w_q_mask    [2];
    logic        w_gnt_alu;
    logic        w_gnt_mem;
    logic [31:0] w_pend_all;

    logic        r_prio;
    logic        r_we;
    logic [4:0]  r_addr;
    logic [31:0] r_data;

    assign w_valid      = {mem_valid, alu_valid};
    assign w_in_rd[0]   = alu_rd;
    assign w_in_rd[1]   = mem_rd;
    assign w_in_data[0] = alu_data;
    assign w_in_data[1] = mem_data;
    assign alu_ready    = w_ready[0];
    assign mem_ready    = w_ready[1];
    assign w_pop        = {w_gnt_mem, w_gnt_alu};

    genvar s, i;
    generate
        for (s = 0; s < 2; s++) begin : g_q
            logic [4:0]    r_rd   [DEPTH];
            logic [31:0]   r_dat  [DEPTH];
            logic [PW-1:0] r_wptr;
            logic [PW-1:0] r_rptr;
            logic [CW-1:0] r_count;
            logic [31:0]   w_acc  [DEPTH+1];

            // Ready is a pure function of occupancy so it never loops back through valid.
            assign w_ready[s]     = (r_count != FULL);
            assign w_nonempty[s]  = (r_count != '0);
            assign w_push[s]      = w_valid[s] && w_ready[s] && !flush;
            assign w_head_rd[s]   = r_rd[r_rptr];
            assign w_head_data[s] = r_dat[r_rptr];

            // Pointer and occupancy tracking; flush empties the queue outright.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else if (flush) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push[s])
                        r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + PW'(1);
                    if (w_pop[s])
                        r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + PW'(1);
                    if (w_push[s] && !w_pop[s])
                        r_count <= r_count + CW'(1);
                    else if (!w_push[s] && w_pop[s])
                        r_count <= r_count - CW'(1);
                end
            end

            // Payload storage needs no reset: validity is carried by the pointers.
            always_ff @(posedge clk) begin
                if (w_push[s]) begin
                    r_rd[r_wptr]  <= w_in_rd[s];
                    r_dat[r_wptr] <= w_in_data[s];
                end
            end

            // A slot is live when it sits in the circular window [rptr, wptr).
            assign w_acc[0] = '0;
            for (i = 0; i < DEPTH; i++) begin : g_ent
                logic w_live;
                assign w_live = (r_count == FULL) ||
                                ((r_count != '0) &&
                                 ((r_wptr > r_rptr) ?
                                  ((PW'(i) >= r_rptr) && (PW'(i) < r_wptr)) :
                                  ((PW'(i) >= r_rptr) || (PW'(i) < r_wptr))));
                assign w_acc[i+1] = w_acc[i] | (w_live ? (32'd1 << r_rd[i]) : 32'd0);
            end
            assign w_q_mask[s] = w_acc[DEPTH];
        end
    endgenerate

    // A lone head wins; with both heads present the prio bit breaks the tie.
    assign w_gnt_alu = !flush && w_nonempty[0] && (!w_nonempty[1] || !r_prio);
    assign w_gnt_mem = !flush && w_nonempty[1] && (!w_nonempty[0] ||  r_prio);

    // Output register and round-robin pointer; rd=0 heads are popped without a strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_prio <= 1'b0;
        end else if (w_gnt_alu) begin
            r_we   <= (w_head_rd[0] != 5'd0);
            r_addr <= w_head_rd[0];
            r_data <= w_head_data[0];
            r_prio <= 1'b1;
        end else if (w_gnt_mem) begin
            r_we   <= (w_head_rd[1] != 5'd0);
            r_addr <= w_head_rd[1];
            r_data <= w_head_data[1];
            r_prio <= 1'b0;
        end else begin
            r_we   <= 1'b0;
        end
    end

    assign w_enable   = r_we;
    assign w_addr     = r_addr;
    assign w_data     = r_data;
    assign w_pend_all = w_q_mask[0] | w_q_mask[1] | (r_we ? (32'd1 << r_addr) : 32'd0);
    assign pending    = w_pend_all & ~32'd1;

`ifdef WB_BYPASS_EN
    // The register file returns the stale value on a same-edge read/write collision.
    assign fwd1_hit  = r_we && (r_addr == rs1) && (rs1 != 5'd0);
    assign fwd2_hit  = r_we && (r_addr == rs2) && (rs2 != 5'd0);
    assign fwd1_data = r_data;
    assign fwd2_data = r_data;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: fixed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based reference.
module tb_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, flush;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        w_enable;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] pending;
`ifdef WB_BYPASS_EN
    logic [4:0]  rs1, rs2;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .flush     (flush),
        .w_enable  (w_enable),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .pending   (pending)
`ifdef WB_BYPASS_EN
        ,
        .rs1       (rs1),
        .rs2       (rs2),
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queues of {rd,data} plus the committed write.
    typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
    ent_t        qa[$];
    ent_t        qm[$];
    logic        m_prio;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic model_reset();
        qa.delete();
        qm.delete();
        m_prio = 1'b0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        foreach (qa[k]) p[qa[k].rd] = 1'b1;
        foreach (qm[k]) p[qm[k].rd] = 1'b1;
        if (m_we) p[m_addr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic model_step();
        bit   ra, rm;
        int   g;
        ent_t e;
        ra = (qa.size() != DEPTH);
        rm = (qm.size() != DEPTH);
        if (flush) begin
            qa.delete();
            qm.delete();
            m_we = 1'b0;
        end else begin
            if (qa.size() != 0 && qm.size() != 0) g = m_prio ? 1 : 0;
            else if (qa.size() != 0)              g = 0;
            else if (qm.size() != 0)              g = 1;
            else                                  g = -1;
            if (g >= 0) begin
                e      = (g == 0) ? qa.pop_front() : qm.pop_front();
                m_addr = e.rd;
                m_data = e.data;
                m_we   = (e.rd != 5'd0);
                m_prio = (g == 0);
            end else begin
                m_we = 1'b0;
            end
            if (alu_valid && ra) qa.push_back('{alu_rd, alu_data});
            if (mem_valid && rm) qm.push_back('{mem_rd, mem_data});
        end
    endtask

    task automatic check_model();
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, qa.size() != DEPTH});
        chk("mem_ready", {31'd0, mem_ready}, {31'd0, qm.size() != DEPTH});
        chk("w_enable",  {31'd0, w_enable},  {31'd0, m_we});
        chk("w_addr",    {27'd0, w_addr},    {27'd0, m_addr});
        chk("w_data",    w_data,             m_data);
        chk("pending",   pending,            model_pending());
`ifdef WB_BYPASS_EN
        chk("fwd1_hit", {31'd0, fwd1_hit}, {31'd0, m_we && m_addr == rs1 && rs1 != 5'd0});
        chk("fwd2_hit", {31'd0, fwd2_hit}, {31'd0, m_we && m_addr == rs2 && rs2 != 5'd0});
        if (m_we) chk("fwd1_data", fwd1_data, m_data);
        if (m_we) chk("fwd2_data", fwd2_data, m_data);
`endif
    endtask

    // Inputs are driven at edge+1; outputs are compared at edge+2, then one clock edge.
    task automatic tick();
        #1;
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        flush     = 1'b0;
    endtask

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] adat;
        logic        mv;  logic [4:0] mrd; logic [31:0] mdat;
        logic        fl;
        logic        ewe; logic [4:0] eaddr; logic [31:0] edata; logic [31:0] epend;
    } vec_t;

    vec_t vecs[12];

    bit saw_alu_full, saw_mem_full;

    initial begin
        // Expected values are what w_*/pending show after that row's edge.
        vecs[0]  = '{1, 5'd3, 32'h11,       1, 5'd4, 32'h22, 0, 0, 5'd0, 32'h0,        32'h18};
        vecs[1]  = '{1, 5'd6, 32'h33,       1, 5'd7, 32'h44, 0, 1, 5'd3, 32'h11,       32'hD8};
        vecs[2]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 1, 5'd4, 32'h22,       32'hD0};
        vecs[3]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 1, 5'd6, 32'h33,       32'hC0};
        vecs[4]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 1, 5'd7, 32'h44,       32'h80};
        vecs[5]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 0, 5'd7, 32'h44,       32'h0};
        vecs[6]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,  0, 0, 5'd7, 32'h44,       32'h20};
        vecs[7]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 1, 5'd5, 32'hDEADBEEF, 32'h20};
        vecs[8]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 0, 5'd5, 32'hDEADBEEF, 32'h0};
        vecs[9]  = '{1, 5'd0, 32'h1234,     0, 5'd0, 32'h0,  0, 0, 5'd5, 32'hDEADBEEF, 32'h0};
        vecs[10] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 0, 5'd0, 32'h1234,     32'h0};
        vecs[11] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 0, 5'd0, 32'h1234,     32'h0};

        rst = 1'b1;
        idle();
        alu_rd = '0; alu_data = '0; mem_rd = '0; mem_data = '0;
`ifdef WB_BYPASS_EN
        rs1 = '0; rs2 = '0;
`endif
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_w_enable", {31'd0, w_enable}, 32'd0);
        chk("rst_w_addr",   {27'd0, w_addr},   32'd0);
        chk("rst_w_data",   w_data,            32'd0);
        chk("rst_pending",  pending,           32'd0);
        chk("rst_ready",    {30'd0, alu_ready, mem_ready}, 32'd3);
        rst = 1'b0;

        // Vector table: round-robin order, single-entry latency, rd=0 drop.
        for (int k = 0; k < 12; k++) begin
            alu_valid = vecs[k].av; alu_rd = vecs[k].ard; alu_data = vecs[k].adat;
            mem_valid = vecs[k].mv; mem_rd = vecs[k].mrd; mem_data = vecs[k].mdat;
            flush     = vecs[k].fl;
            tick();
            chk($sformatf("vec%0d_we", k),   {31'd0, w_enable}, {31'd0, vecs[k].ewe});
            chk($sformatf("vec%0d_addr", k), {27'd0, w_addr},   {27'd0, vecs[k].eaddr});
            chk($sformatf("vec%0d_data", k), w_data,            vecs[k].edata);
            chk($sformatf("vec%0d_pend", k), pending,           vecs[k].epend);
        end
        idle();

        // Flush with one entry on w_* and one queued; a push during flush is dropped.
        alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h99;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hAA;
        tick();
        idle();
        tick();
        chk("flush_pre_we",   {31'd0, w_enable}, 32'd1);
        chk("flush_pre_addr", {27'd0, w_addr},   32'd10);
        flush = 1'b1; alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hCC;
        tick();
        idle();
        chk("flush_we",    {31'd0, w_enable}, 32'd0);
        chk("flush_pend",  pending,           32'd0);
        chk("flush_ready", {30'd0, alu_ready, mem_ready}, 32'd3);
        tick();
        chk("flush_post_we", {31'd0, w_enable}, 32'd0);
        tick();

        // Constant contention on both sources fills the queues.
        saw_alu_full = 0;
        saw_mem_full = 0;
        for (int k = 0; k < 8; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(k + 1);  alu_data = $urandom;
            mem_valid = 1'b1; mem_rd = 5'(k + 16); mem_data = $urandom;
            if (!alu_ready) saw_alu_full = 1;
            if (!mem_ready) saw_mem_full = 1;
            tick();
        end
        idle();
        for (int k = 0; k < 2 * DEPTH + 2; k++) tick();
        chk("alu_full_seen", {31'd0, saw_alu_full}, 32'd1);
        chk("mem_full_seen", {31'd0, saw_mem_full}, 32'd1);
        chk("drained_pend",  pending, 32'd0);

        // Back-to-back ALU burst, no MEM traffic.
        for (int k = 0; k < DEPTH + 2; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(k + 20); alu_data = 32'h100 + 32'(k);
            tick();
        end
        idle();
        for (int k = 0; k < 3; k++) tick();

`ifdef WB_BYPASS_EN
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h55;
        tick();
        idle();
        tick();
        rs1 = 5'd7; rs2 = 5'd0;
        #1;
        chk("byp_fwd1_hit",  {31'd0, fwd1_hit}, 32'd1);
        chk("byp_fwd1_data", fwd1_data,         32'h55);
        chk("byp_fwd2_hit",  {31'd0, fwd2_hit}, 32'd0);
        tick();
        chk("byp_stale_hit", {31'd0, fwd1_hit}, 32'd0);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            alu_valid = ($urandom_range(0, 2) != 0);
            mem_valid = ($urandom_range(0, 2) != 0);
            alu_rd    = 5'($urandom_range(0, 31));
            mem_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            mem_data  = $urandom;
            flush     = ($urandom_range(0, 24) == 0);
`ifdef WB_BYPASS_EN
            rs1 = ($urandom_range(0, 1) != 0) ? w_addr : 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
`endif
            tick();
        end
        idle();

        // Asynchronous reset between edges with traffic in flight.
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
        tick();
        idle();
        tick();
        chk("pre_rst_we", {31'd0, w_enable}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_we",    {31'd0, w_enable}, 32'd0);
        chk("async_rst_addr",  {27'd0, w_addr},   32'd0);
        chk("async_rst_pend",  pending,           32'd0);
        chk("async_rst_ready", {30'd0, alu_ready, mem_ready}, 32'd3);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
